// File: rtl/rv32_exec_unit.sv
// Multi-cycle RV32I decode/execute/writeback unit: instruction handshake, internal register
// file, ALU with optional bit-serial shifter, and a load/store port with byte lanes and timeout.
module rv32_exec_unit #(
    parameter int NREGS        = 32,
    parameter int SERIAL_SHIFT = 0,
    parameter int TIMEOUT      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        illegal
);

    localparam int         AW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MEM, WB} state_t;
    state_t state, state_nx;

    logic [31:0] rf [NREGS];
    logic [31:0] ir, res_q, tcnt_q;
    logic [4:0]  cnt_q;
    logic        done_q, ill_q;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub, input logic sra,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, asr;
        sa  = a;
        sb  = b;
        asr = sa >>> b[4:0];
        case (f3)
            3'b000:  alu = sub ? a - b : a + b;
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, sa < sb};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = sra ? asr : a >> b[4:0];
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic [31:0] shift1(input logic [2:0] f3, input logic sra, input logic [31:0] x);
        shift1 = (f3 == 3'b001) ? {x[30:0], 1'b0} : {sra & x[31], x[31:1]};
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b100:  load_ext = {24'd0, s[7:0]};
            3'b101:  load_ext = {16'd0, s[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, rs1v, rs2v, alu_b, maddr, st_data;
    logic [3:0]  st_strb;
    logic        is_op, is_opi, is_lui, is_ld, is_st, op_ok, opi_ok, ld_ok, st_ok;
    logic        mis, reg_bad, legal, go_shift, mem_to, accept;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};

    assign rs1v = (rs1 == 5'd0 || {1'b0, rs1} >= NR) ? '0 : rf[rs1[AW-1:0]];
    assign rs2v = (rs2 == 5'd0 || {1'b0, rs2} >= NR) ? '0 : rf[rs2[AW-1:0]];

    assign is_op  = opc == 7'b0110011;
    assign is_opi = opc == 7'b0010011;
    assign is_lui = opc == 7'b0110111;
    assign is_ld  = opc == 7'b0000011;
    assign is_st  = opc == 7'b0100011;

    assign op_ok  = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    assign opi_ok = (f3 == 3'b001) ? (f7 == 7'd0) :
                    (f3 == 3'b101) ? (f7 == 7'd0 || f7 == 7'b0100000) : 1'b1;
    assign ld_ok  = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    assign st_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);

    assign maddr   = rs1v + (is_st ? imm_s : imm_i);
    assign mis     = (f3[1:0] == 2'b01 && maddr[0]) || (f3[1:0] == 2'b10 && maddr[1:0] != 2'b00);
    // Only register fields the instruction actually uses are range-checked.
    assign reg_bad = ({1'b0, rd}  >= NR && (is_op || is_opi || is_lui || is_ld)) ||
                     ({1'b0, rs1} >= NR && (is_op || is_opi || is_ld || is_st)) ||
                     ({1'b0, rs2} >= NR && (is_op || is_st));
    assign legal   = ((is_op && op_ok) || (is_opi && opi_ok) || is_lui ||
                      (((is_ld && ld_ok) || (is_st && st_ok)) && !mis)) && !reg_bad;

    assign alu_b    = is_op ? rs2v : imm_i;
    assign go_shift = (SERIAL_SHIFT != 0) && (is_op || is_opi) && (f3[1:0] == 2'b01) && (alu_b[4:0] != 5'd0);
    assign mem_to   = (TIMEOUT > 0) && (tcnt_q == 32'(TIMEOUT - 1));
    assign accept   = (state == IDLE) && instr_valid && !done_q;
    assign wb_rd    = rd;
    assign wb_data  = res_q;

    always_comb begin
        st_data = rs2v;
        st_strb = 4'b1111;
        case (f3[1:0])
            2'b00: begin st_data = {4{rs2v[7:0]}};  st_strb = 4'b0001 << maddr[1:0]; end
            2'b01: begin st_data = {2{rs2v[15:0]}}; st_strb = 4'b0011 << maddr[1:0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        wb_en       = 1'b0;
        done        = done_q;
        illegal     = ill_q;
        case (state)
            IDLE: begin
                instr_ready = !done_q && !rst;
                if (accept) state_nx = EXEC;
            end
            EXEC: begin
                if (!legal) begin
                    done     = 1'b1;
                    illegal  = 1'b1;
                    state_nx = IDLE;
                end else if (is_ld || is_st) state_nx = MEM;
                else if (go_shift)           state_nx = SHIFT;
                else                         state_nx = WB;
            end
            SHIFT: if (cnt_q == 5'd1) state_nx = WB;
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack)     state_nx = is_ld ? WB : IDLE;
                else if (mem_to) state_nx = IDLE;
            end
            WB: begin
                wb_en    = rd != 5'd0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Store completion and timeout are reported one cycle after MEM exits, from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            case (state)
                IDLE: if (accept) ir <= instr;
                EXEC: begin
                    res_q  <= is_lui ? {ir[31:12], 12'd0} : go_shift ? rs1v : alu(f3, is_op && f7[5], f7[5], rs1v, alu_b);
                    cnt_q  <= alu_b[4:0];
                    tcnt_q <= '0;
                    if (legal && (is_ld || is_st)) begin
                        mem_we    <= is_st;
                        mem_addr  <= maddr;
                        mem_wdata <= st_data;
                        mem_wstrb <= is_st ? st_strb : 4'b0000;
                    end
                end
                SHIFT: begin
                    res_q <= shift1(f3, f7[5], res_q);
                    cnt_q <= cnt_q - 5'd1;
                end
                MEM: begin
                    if (mem_ack) begin
                        if (is_ld) res_q <= load_ext(f3, mem_addr[1:0], mem_rdata);
                        else       done_q <= 1'b1;
                    end else if (mem_to) begin
                        done_q <= 1'b1;
                        ill_q  <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (state == WB && rd != 5'd0) begin
            rf[rd[AW-1:0]] <= res_q;
        end
    end

endmodule
